// File: rtl/stream_arb2.sv
// Two-source packet-aware round-robin arbiter feeding a registered output stage.
// A packet (terminated by last) is never interleaved with the other source.
module stream_arb2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    input  logic             a_last,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    input  logic             b_last,
    output logic             b_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             sel_q, sel_d;

    logic grant_a, grant_b;
    logic load, acc_a, acc_b, acc_last;

    // A locked packet keeps its grant even while its source is idle.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state_q)
            LOCK_A: grant_a = 1'b1;
            LOCK_B: grant_b = 1'b1;
            default: begin
                if (a_valid && b_valid) begin
                    grant_a = !rr_q;
                    grant_b = rr_q;
                end else begin
                    grant_a = a_valid;
                    grant_b = b_valid;
                end
            end
        endcase
    end

    assign load     = !out_valid_q || out_ready;
    assign a_ready  = load && grant_a;
    assign b_ready  = load && grant_b;
    assign acc_a    = a_ready && a_valid;
    assign acc_b    = b_ready && b_valid;
    assign acc_last = acc_a ? a_last : b_last;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sel_d       = sel_q;
        if (acc_a || acc_b) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_a ? a_data : b_data;
            out_last_d  = acc_last;
            sel_d       = acc_b;
            if (acc_last) begin
                state_d = IDLE;
                rr_d    = acc_a;
            end else begin
                state_d = acc_a ? LOCK_A : LOCK_B;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            sel_q       <= sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sel       = sel_q;

endmodule

// File: doc/stream_arb2.md
# stream_arb2

Two-source, packet-aware round-robin arbiter with a registered output stage. It sits directly upstream of the 2:1 byte mux. It also produces the select line that names which source owns the current output beat. It merges two valid/ready byte streams into one stream at up to one beat per cycle. A packet, delimited by a `last` flag, is never interleaved with the other source.

## Interface
- `WIDTH`, default 8: data width of each source and of the output.
- `clk` in 1: the only clock; everything is sampled on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `a_data` in WIDTH: source A payload.
- `a_valid` in 1: source A beat available.
- `a_last` in 1: source A beat is the final beat of its packet.
- `a_ready` out 1: A beat accepted this cycle when `a_valid && a_ready`.
- `b_data`, `b_valid`, `b_last` in, and `b_ready` out: same meanings as the A signals, for source B.
- `out_data` out WIDTH: registered payload.
- `out_valid` out 1: output register holds a beat.
- `out_last` out 1: registered `last` of the held beat.
- `out_ready` in 1: downstream accepts the beat when `out_valid && out_ready`.
- `sel` out 1: registered source of the held beat, 0 = A, 1 = B. Follows the mux convention 0 → first input.

## Operation
- Output register: holds `{data, last, src}` plus `out_valid`.
  - `load = !out_valid || out_ready`. The register is free, or it is being drained this cycle.
- Grant logic:
  - At most one of `a_ready` and `b_ready` is high in any cycle.
  - `a_ready = load && grant_a`, and `b_ready = load && grant_b`.
  - The grant is computed combinationally from state, pointer and the valids. Ready never depends on the ready of its own source.
- FSM states are IDLE, LOCK_A and LOCK_B.
- IDLE:
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the source the round-robin pointer `rr` names. `rr` = 0 names A; `rr` = 1 names B.
  - Accepted beat with last=0: go to LOCK_x of the granted source.
  - Accepted beat with last=1: stay in IDLE.
- LOCK_A: grant only A; B is never granted, even if A is idle. An accepted A beat with last=1 moves the FSM to IDLE. LOCK_B mirrors this for B.
- Pointer `rr`: updates only on an accepted beat with last=1. It then points to the other source (A finishes → `rr` = 1). There is no update mid-packet and none when no beat is accepted.
- Load: on accept, `out_data`, `out_last` and `sel` take the granted source's data, last and id; `out_valid` = 1.
- Drain: a drain with no accept in the same cycle sets `out_valid` = 0. `out_data`, `out_last` and `sel` hold their last values.
- Simultaneous drain and accept: the new beat replaces the old one in the same edge and `out_valid` stays 1. Full throughput, no bubble.
- Reset (async assert, any time, including mid-packet):
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `sel` = 0.
  - FSM = IDLE, `rr` = 0 (A preferred).
  - A packet interrupted by reset is dropped from arbiter state; the first beat after reset is arbitrated as new.
- Deassertion of `rst_n` takes effect at the next rising edge; normal operation starts from that edge.

## Timing
- Latency: a beat accepted at edge N is presented on `out_data`/`out_valid`/`sel` after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while `out_ready` = 1 and a granted source is valid.
- Switching between packets costs no idle cycle.
- Combinational paths:
  - `a_ready`/`b_ready` depend on `out_ready`, `out_valid`, FSM state, `rr`, `a_valid` and `b_valid`.
  - There is no combinational path from any input to `out_*` or `sel`.
- Backpressure:
  - With `out_valid` = 1 and `out_ready` = 0, both readies are 0 and every output holds.
  - Sources must hold data, valid and last stable until accepted.
- `sel` changes only on a load edge, so the downstream mux select is glitch-free relative to `clk`.

## Test plan
- Reset values: assert `rst_n` = 0 mid-stream.
  - Required immediately, without waiting for a clock edge: `out_valid` = 0, `out_data` = 8'h00, `sel` = 0.
  - After release, with both sources valid, A is granted first.
- Round-robin on single-beat packets, `out_ready` held at 1:
  - Stimulus: A continuously presents 8'h01 (last=1) and B continuously presents 8'h03 (last=1).
  - Required: output sequence 01,03,01,03 on consecutive cycles, with `sel` 0,1,0,1 and no bubbles.
- Packet lock:
  - Stimulus: A sends 8'h10, 8'h11, 8'h12, with last on 12. B is valid throughout with 8'h20 (last=1). A drops valid for 2 cycles between 11 and 12.
  - Required: output sequence 10,11,12,20. B is not granted during the A gap, and `b_ready` stays 0 until 12 is accepted.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 for 3 cycles while 8'h05 is held in the output register.
  - Required: `out_data` = 05, `out_valid` = 1, and `a_ready` = `b_ready` = 0 throughout.
  - After `out_ready` rises, the next beat loads in the drain cycle.
- Single source: only B is valid, sending 8'hAA then 8'hBB, both last=1. Required: both beats pass back-to-back with `sel` = 1, and `rr` ends pointing to A.
- Reset mid-packet:
  - Stimulus: A sends 8'h30 (last=0), then reset pulses; after release, B sends 8'h40 (last=1) and A sends 8'h31.
  - Required: the FSM is in IDLE after reset and A is granted first, so 31 precedes 40. No lock survives reset.
